rpc_flow_dispatcher: RTL
========================

// Module: rpc_flow_dispatcher
// PURPOSE
//  Upstream feeder of the CCI-P TX path: takes RPCs from the NIC RPC unit, assigns each a TX flow id
//  (round-robin or connection hash), buffers them in a dispatch FIFO and presents them one per cycle
//  on rpc_out/rpc_out_valid/rpc_flow_id_out, throttled by ccip_tx_ready. Input has no backpressure:
//  arrivals when the FIFO is full are dropped and counted.
// PARAMETERS
//  LMAX_NUM_OF_FLOWS  1   log2 of max TX flows; width of flow ids
//  LDISP_FIFO_DEPTH   4   log2 of dispatch FIFO depth (16 entries)
//  CONN_ID_WIDTH      16  width of connection id used for hashing
// PORTS
//  clk              in   1                  clock
//  reset_n          in   1                  async active-low reset
//  start            in   1                  enable; low = ignore inputs, hold FIFO, no pops
//  number_of_flows  in   LMAX_NUM_OF_FLOWS  highest valid flow index (inclusive)
//  lb_mode          in   1                  0 = round-robin, 1 = connection hash
//  rpc_in           in   $bits(RpcIf)       RPC payload
//  rpc_in_valid     in   1                  payload valid, single-cycle, no ready
//  rpc_conn_id_in   in   CONN_ID_WIDTH      connection id, valid with rpc_in_valid
//  ccip_tx_ready    in   1                  downstream may accept an RPC this cycle
//  rpc_out          out  $bits(RpcIf)       RPC to transmitter
//  rpc_out_valid    out  1                  one-cycle strobe per dispatched RPC
//  rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow id for rpc_out
//  fifo_count       out  LDISP_FIFO_DEPTH+1 current FIFO occupancy
//  drop_count       out  32                 RPCs dropped on full, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO empty, rd/wr ptrs 0, rr_ptr 0, rpc_out_valid 0, rpc_out 0,
//   rpc_flow_id_out 0, fifo_count 0, drop_count 0. Reset mid-operation discards all buffered RPCs.
//  Stage 1 (edge E0): if start && rpc_in_valid, register payload and computed flow into s1; s1_valid<=1.
//   Flow select: lb_mode=0: flow=rr_ptr; rr_ptr <= (rr_ptr==number_of_flows) ? 0 : rr_ptr+1, advanced
//   only on accepted valid inputs (drops included). lb_mode=1: h = XOR of all LMAX_NUM_OF_FLOWS-bit
//   chunks of rpc_conn_id_in (top chunk zero-padded); flow = h & number_of_flows. Hash mode requires
//   number_of_flows = 2^k-1; other values are unsupported config. rr_ptr holds in hash mode.
//  Stage 2 (edge E1): s1_valid && !full -> write {payload,flow} to FIFO; s1_valid && full -> drop,
//   drop_count += 1 (saturates at 32'hFFFF_FFFF). full evaluated as count==2^LDISP_FIFO_DEPTH after
//   accounting for a same-cycle pop: pop and push in the same cycle on a full FIFO is accepted, count holds.
//  Pop (every edge): if start && ccip_tx_ready && !empty -> rpc_out/rpc_flow_id_out <= head,
//   rpc_out_valid <= 1, rd_ptr++; else rpc_out_valid <= 0, rpc_out/rpc_flow_id_out hold.
//  Latency: input at E0 -> rpc_out_valid high after E2 (2 cycles) into an empty FIFO with ready high.
//  Throughput: 1 RPC/cycle sustained; order preserved globally (single FIFO, no per-flow reordering).
//  Pointers are LDISP_FIFO_DEPTH bits, wrap modulo depth; fifo_count = registered occupancy,
//   +1 on push only, -1 on pop only, unchanged on both or neither.
//  start falling: in-flight s1 entry still written; no new inputs, no pops; FIFO contents retained.
//  ccip_tx_ready low: no pops; FIFO keeps filling; overflow drops as above.
//  number_of_flows change while running: rr_ptr > number_of_flows wraps to 0 on next advance.
// TESTING
//  1 Reset: reset_n low mid-stream with 5 RPCs buffered -> all outputs 0 immediately, fifo_count 0.
//  2 RR: number_of_flows=3, lb_mode=0, 8 back-to-back RPCs, ready=1 -> flow ids 0,1,2,3,0,1,2,3,
//    first rpc_out_valid 2 cycles after first input, 8 consecutive valid cycles, payload order kept.
//  3 Hash: LMAX=2, number_of_flows=3, conn_id=16'h00B4 -> h=0^3^1^2=0 -> flow 0; conn_id=16'h0001 -> flow 1.
//  4 Overflow: ready=0, 20 RPCs, depth 16 -> fifo_count 16, drop_count 4; ready=1 -> 16 RPCs out in order.
//  5 Full+simultaneous: FIFO full, ready=1, input each cycle -> no drops, fifo_count stays 16.
//  6 start low: start=0 with 3 buffered, inputs toggling -> no outputs, count 3, drop_count unchanged;
//    start=1 -> 3 RPCs drain.

Source files
------------

// File: rtl/rpc_flow_dispatcher_if.sv
// RPC handshake bundle between the NIC RPC unit, the flow dispatcher and the CCI-P transmitter.
// The dispatcher sits on the slave modport; the producer/consumer side uses master.
interface rpc_flow_dispatcher_if #(
  parameter int DATA_W            = 64,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int CONN_ID_WIDTH     = 16
);
  logic [DATA_W-1:0]            rpc_in;
  logic                         rpc_in_valid;
  logic [CONN_ID_WIDTH-1:0]     rpc_conn_id_in;
  logic                         ccip_tx_ready;
  logic [DATA_W-1:0]            rpc_out;
  logic                         rpc_out_valid;
  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out;

  modport master (
    output rpc_in, rpc_in_valid, rpc_conn_id_in, ccip_tx_ready,
    input  rpc_out, rpc_out_valid, rpc_flow_id_out
  );

  modport slave (
    input  rpc_in, rpc_in_valid, rpc_conn_id_in, ccip_tx_ready,
    output rpc_out, rpc_out_valid, rpc_flow_id_out
  );
endinterface

// File: rtl/rpc_flow_dispatcher.sv
// Assigns a TX flow id to each incoming RPC (round-robin or connection hash), buffers it in a
// dispatch FIFO and releases one RPC per cycle to the CCI-P transmitter when it is ready.
module rpc_flow_dispatcher #(
  parameter int DATA_W            = 64,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LDISP_FIFO_DEPTH  = 4,
  parameter int CONN_ID_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
  input  logic                          lb_mode,
  rpc_flow_dispatcher_if.slave          bus,
  output logic [LDISP_FIFO_DEPTH:0]     fifo_count,
  output logic [31:0]                   drop_count
);

  localparam int FLOW_W = LMAX_NUM_OF_FLOWS;
  localparam int CHUNKS = (CONN_ID_WIDTH + FLOW_W - 1) / FLOW_W;
  localparam int ENT_W  = DATA_W + FLOW_W;
  localparam logic [LDISP_FIFO_DEPTH:0] FULL_CNT = {1'b1, {LDISP_FIFO_DEPTH{1'b0}}};

  function automatic logic [FLOW_W-1:0] conn_hash(input logic [CONN_ID_WIDTH-1:0] cid);
    logic [CHUNKS*FLOW_W-1:0] padded;
    logic [FLOW_W-1:0]        h;
    padded                    = '0;
    padded[CONN_ID_WIDTH-1:0] = cid;
    h                         = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      h = h ^ padded[i*FLOW_W +: FLOW_W];
    end
    return h;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic                    acc_p0;
  logic [FLOW_W-1:0]       flow_p0;
  logic [FLOW_W-1:0]       rr_ptr;

  logic                    vld_p1;
  logic [DATA_W-1:0]       rpc_p1;
  logic [FLOW_W-1:0]       flow_p1;

  logic [ENT_W-1:0]        mem [0:(1<<LDISP_FIFO_DEPTH)-1];
  logic [LDISP_FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
  logic                    pop, push, drop, full_eff;

  logic                    vld_p2;
  logic [DATA_W-1:0]       rpc_p2;
  logic [FLOW_W-1:0]       flow_p2;

  // ---- stage 0: accept and pick a flow ----
  always_comb begin
    acc_p0  = start && bus.rpc_in_valid;
    flow_p0 = lb_mode ? (conn_hash(bus.rpc_conn_id_in) & number_of_flows) : rr_ptr;
  end

  // Drops also advance the pointer; an out-of-range pointer after a config change wraps to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (acc_p0 && !lb_mode) begin
      rr_ptr <= (rr_ptr >= number_of_flows) ? '0 : rr_ptr + 1'b1;
    end
  end

  // ---- stage 1: registered RPC awaiting FIFO write ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= acc_p0;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      rpc_p1  <= bus.rpc_in;
      flow_p1 <= flow_p0;
    end
  end

  // ---- stage 2: FIFO write / drop, pop to output ----
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the incoming entry.
  always_comb begin
    pop      = start && bus.ccip_tx_ready && (fifo_count != '0);
    full_eff = (fifo_count == FULL_CNT) && !pop;
    push     = vld_p1 && !full_eff;
    drop     = vld_p1 && full_eff;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rpc_p1, flow_p1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) drop_count <= sat_inc32(drop_count);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2  <= 1'b0;
      rpc_p2  <= '0;
      flow_p2 <= '0;
    end else begin
      vld_p2 <= pop;
      if (pop) {rpc_p2, flow_p2} <= mem[rd_ptr];
    end
  end

  assign bus.rpc_out         = rpc_p2;
  assign bus.rpc_out_valid   = vld_p2;
  assign bus.rpc_flow_id_out = flow_p2;

endmodule
